// File: rtl/bp_pkg.sv
// Shared types for the branch predictor front end and the EXE-stage resolve logic.
//   addr_t      : PC / target address type
//   pred_meta_t : prediction record carried alongside each instruction
//   PC_INC      : sequential PC increment
package bp_pkg;

    localparam int unsigned BP_ADDR_WIDTH = 64;

    typedef logic [BP_ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        logic  pred_taken;
        addr_t pred_target;
    } pred_meta_t;

    localparam addr_t PC_INC = BP_ADDR_WIDTH'(4);

endpackage : bp_pkg

// File: rtl/bp_meta_stage.sv
// One pipeline register holding a prediction record.
//   clk, rst  : clock, async active-high reset
//   load_en   : capture d this edge
//   bubble    : write an invalid entry this edge, regardless of load_en
//   flush     : invalidate the entry this edge (highest priority)
//   d / q     : incoming / held prediction record
module bp_meta_stage
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic       bubble,
    input  logic       flush,
    input  pred_meta_t d,
    output pred_meta_t q
);

    pred_meta_t entry_d;
    pred_meta_t entry_q;

    // Next entry: flush/bubble only drop the valid bit, payload is don't-care.
    always_comb begin
        entry_d = entry_q;
        if (flush || bubble) begin
            entry_d.valid = 1'b0;
        end else if (load_en) begin
            entry_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule : bp_meta_stage

// File: rtl/branch_resolve_unit.sv
// Carries IF-stage predictions through IF/ID and ID/EXE, checks them against the
// actual branch outcome in EXE, redirects fetch on mispredict, and drives the
// predictor update port plus saturating branch/mispredict statistics.
//   clk, rst                       : clock, async active-high reset
//   valid_if, pc_if, jump_if,
//   pc_target_if                   : fetched instruction and its prediction
//   stall_id, stall_exe, flush     : pipeline control
//   is_branch_exe, taken_exe,
//   target_exe                     : actual outcome of the EXE instruction
//   redirect, redirect_pc          : combinational fetch restart
//   upd_valid/pc/target/taken      : registered predictor update
//   branch_cnt, mispred_cnt        : saturating statistics
module branch_resolve_unit #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_if,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    input  logic                  jump_if,
    input  logic [ADDR_WIDTH-1:0] pc_target_if,
    input  logic                  stall_id,
    input  logic                  stall_exe,
    input  logic                  flush,
    input  logic                  is_branch_exe,
    input  logic                  taken_exe,
    input  logic [ADDR_WIDTH-1:0] target_exe,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  upd_valid,
    output logic [ADDR_WIDTH-1:0] upd_pc,
    output logic [ADDR_WIDTH-1:0] upd_target,
    output logic                  upd_taken,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    import bp_pkg::*;

    pred_meta_t if_entry;
    pred_meta_t ifid_q;
    pred_meta_t idex_q;

    logic                  resolve;
    logic                  mispred;
    logic                  actual_taken;
    logic                  idex_load;
    logic                  idex_bubble;
    addr_t                 seq_pc;
    logic [ADDR_WIDTH-1:0] seq_pc_w;

    logic                  resolved_d,   resolved_q;
    logic                  upd_valid_d,  upd_valid_q;
    logic [ADDR_WIDTH-1:0] upd_pc_d,     upd_pc_q;
    logic [ADDR_WIDTH-1:0] upd_target_d, upd_target_q;
    logic                  upd_taken_d,  upd_taken_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_d, branch_cnt_q;
    logic [CNT_WIDTH-1:0]  mispred_cnt_d, mispred_cnt_q;

    // Prediction record entering IF/ID.
    always_comb begin
        if_entry             = '0;
        if_entry.valid       = valid_if;
        if_entry.pc          = BP_ADDR_WIDTH'(pc_if);
        if_entry.pred_taken  = jump_if;
        if_entry.pred_target = BP_ADDR_WIDTH'(pc_target_if);
    end

    // ID/EXE takes a bubble when ID stalls but EXE advances, or on redirect.
    assign idex_bubble = redirect || (stall_id && !stall_exe);
    assign idex_load   = !stall_exe || redirect;

    bp_meta_stage u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_en (!stall_id),
        .bubble  (redirect),
        .flush   (flush),
        .d       (if_entry),
        .q       (ifid_q)
    );

    bp_meta_stage u_id_exe (
        .clk     (clk),
        .rst     (rst),
        .load_en (!stall_exe),
        .bubble  (idex_bubble),
        .flush   (flush),
        .d       (ifid_q),
        .q       (idex_q)
    );

    // Resolve comparator; a non-branch predicted taken counts as an alias mispredict.
    always_comb begin
        seq_pc       = idex_q.pc + PC_INC;
        seq_pc_w     = ADDR_WIDTH'(seq_pc);
        actual_taken = is_branch_exe && taken_exe;
        resolve      = idex_q.valid && !resolved_q && !flush;
        mispred      = 1'b0;
        if (resolve) begin
            if (is_branch_exe) begin
                mispred = (idex_q.pred_taken != taken_exe) ||
                          (taken_exe && (idex_q.pred_target != BP_ADDR_WIDTH'(target_exe)));
            end else begin
                mispred = idex_q.pred_taken;
            end
        end
        redirect    = mispred;
        redirect_pc = '0;
        if (mispred) begin
            redirect_pc = actual_taken ? target_exe : seq_pc_w;
        end
    end

    // Update record, resolved flag and statistics for the next edge.
    always_comb begin
        upd_valid_d   = resolve && (is_branch_exe || idex_q.pred_taken);
        upd_pc_d      = '0;
        upd_target_d  = '0;
        upd_taken_d   = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        resolved_d    = resolved_q;

        if (upd_valid_d) begin
            upd_pc_d     = ADDR_WIDTH'(idex_q.pc);
            upd_taken_d  = actual_taken;
            upd_target_d = is_branch_exe ? target_exe : seq_pc_w;
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            end
        end
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end

        // A held EXE entry resolves once; any new load of ID/EXE rearms it.
        if (flush || idex_load) begin
            resolved_d = 1'b0;
        end else if (resolve && stall_exe) begin
            resolved_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolved_q    <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_taken_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            resolved_q    <= resolved_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_taken_q   <= upd_taken_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_target  = upd_target_q;
    assign upd_taken   = upd_taken_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    localparam int unsigned AW = 64;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_if;
    logic [AW-1:0] pc_if;
    logic          jump_if;
    logic [AW-1:0] pc_target_if;
    logic          stall_id;
    logic          stall_exe;
    logic          flush;
    logic          is_branch_exe;
    logic          taken_exe;
    logic [AW-1:0] target_exe;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_if      (valid_if),
        .pc_if         (pc_if),
        .jump_if       (jump_if),
        .pc_target_if  (pc_target_if),
        .stall_id      (stall_id),
        .stall_exe     (stall_exe),
        .flush         (flush),
        .is_branch_exe (is_branch_exe),
        .taken_exe     (taken_exe),
        .target_exe    (target_exe),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_if(input logic v, input logic [AW-1:0] pc, input logic j, input logic [AW-1:0] t);
        valid_if     = v;
        pc_if        = pc;
        jump_if      = j;
        pc_target_if = t;
    endtask

    task automatic set_exe(input logic b, input logic tk, input logic [AW-1:0] tg);
        is_branch_exe = b;
        taken_exe     = tk;
        target_exe    = tg;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_redirect"},    64'(redirect),    64'd0);
        chk({tag, "_redirect_pc"}, redirect_pc,      64'd0);
        chk({tag, "_upd_valid"},   64'(upd_valid),   64'd0);
        chk({tag, "_upd_pc"},      upd_pc,           64'd0);
        chk({tag, "_upd_target"},  upd_target,       64'd0);
        chk({tag, "_upd_taken"},   64'(upd_taken),   64'd0);
        chk({tag, "_branch_cnt"},  64'(branch_cnt),  64'd0);
        chk({tag, "_mispred_cnt"}, 64'(mispred_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_if(1'b0, '0, 1'b0, '0);
        set_exe(1'b0, 1'b0, '0);
        stall_id  = 1'b0;
        stall_exe = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Correctly predicted taken branch
        set_if(1'b1, 64'h100, 1'b1, 64'h200);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        set_exe(1'b1, 1'b1, 64'h200);
        settle();
        chk("ok_redirect", 64'(redirect), 64'd0);
        tick();
        set_exe(1'b0, 1'b0, '0);
        settle();
        chk("ok_upd_valid",  64'(upd_valid),   64'd1);
        chk("ok_upd_taken",  64'(upd_taken),   64'd1);
        chk("ok_upd_pc",     upd_pc,           64'h100);
        chk("ok_upd_target", upd_target,       64'h200);
        chk("ok_branch_cnt", 64'(branch_cnt),  64'd1);
        chk("ok_mispred",    64'(mispred_cnt), 64'd0);
        chk("ok_redirect2",  64'(redirect),    64'd0);
        tick();
        settle();
        chk("ok_upd_pulse",  64'(upd_valid),   64'd0);

        // Predicted taken, actually not taken; younger instructions must be squashed
        set_if(1'b1, 64'h100, 1'b1, 64'h200);
        tick();
        set_if(1'b1, 64'h104, 1'b1, 64'h300);
        tick();
        set_if(1'b1, 64'h108, 1'b1, 64'h400);
        set_exe(1'b1, 1'b0, 64'h500);
        settle();
        chk("nt_redirect",    64'(redirect), 64'd1);
        chk("nt_redirect_pc", redirect_pc,   64'h104);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        set_exe(1'b0, 1'b0, '0);
        settle();
        chk("nt_idex_squashed", 64'(redirect),    64'd0);
        chk("nt_upd_valid",     64'(upd_valid),   64'd1);
        chk("nt_upd_taken",     64'(upd_taken),   64'd0);
        chk("nt_upd_target",    upd_target,       64'h500);
        chk("nt_upd_pc",        upd_pc,           64'h100);
        chk("nt_mispred",       64'(mispred_cnt), 64'd1);
        chk("nt_branch_cnt",    64'(branch_cnt),  64'd2);
        tick();
        settle();
        chk("nt_ifid_squashed", 64'(redirect),  64'd0);
        chk("nt_upd_pulse",     64'(upd_valid), 64'd0);

        // Target mismatch
        set_if(1'b1, 64'h100, 1'b1, 64'h200);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        set_exe(1'b1, 1'b1, 64'h300);
        settle();
        chk("tm_redirect",    64'(redirect), 64'd1);
        chk("tm_redirect_pc", redirect_pc,   64'h300);
        tick();
        set_exe(1'b0, 1'b0, '0);
        settle();
        chk("tm_upd_target", upd_target,       64'h300);
        chk("tm_upd_taken",  64'(upd_taken),   64'd1);
        chk("tm_mispred",    64'(mispred_cnt), 64'd2);
        chk("tm_branch_cnt", 64'(branch_cnt),  64'd3);

        // Alias: non-branch predicted taken
        set_if(1'b1, 64'h40, 1'b1, 64'h80);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        settle();
        chk("al_redirect",    64'(redirect), 64'd1);
        chk("al_redirect_pc", redirect_pc,   64'h44);
        tick();
        settle();
        chk("al_upd_valid",  64'(upd_valid),   64'd1);
        chk("al_upd_taken",  64'(upd_taken),   64'd0);
        chk("al_upd_target", upd_target,       64'h44);
        chk("al_branch_cnt", 64'(branch_cnt),  64'd4);
        chk("al_mispred",    64'(mispred_cnt), 64'd3);

        // Plain non-branch, not predicted taken: nothing happens
        set_if(1'b1, 64'h60, 1'b0, '0);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        settle();
        chk("nb_redirect", 64'(redirect), 64'd0);
        tick();
        settle();
        chk("nb_upd_valid",  64'(upd_valid),  64'd0);
        chk("nb_branch_cnt", 64'(branch_cnt), 64'd4);

        // Mispredicting branch held in EXE
        set_if(1'b1, 64'h100, 1'b0, '0);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        stall_exe = 1'b1;
        set_exe(1'b1, 1'b1, 64'h700);
        settle();
        chk("st_redirect_c1", 64'(redirect), 64'd1);
        chk("st_redirect_pc", redirect_pc,   64'h700);
        tick();
        settle();
        chk("st_redirect_c2", 64'(redirect),    64'd0);
        chk("st_upd_c2",      64'(upd_valid),   64'd1);
        chk("st_mispred_c2",  64'(mispred_cnt), 64'd4);
        chk("st_branch_c2",   64'(branch_cnt),  64'd5);
        tick();
        settle();
        chk("st_redirect_c3", 64'(redirect),    64'd0);
        chk("st_upd_c3",      64'(upd_valid),   64'd0);
        chk("st_mispred_c3",  64'(mispred_cnt), 64'd4);
        stall_exe = 1'b0;
        set_exe(1'b0, 1'b0, '0);
        tick();

        // Correctly predicted branch held in EXE resolves exactly once
        set_if(1'b1, 64'h200, 1'b1, 64'h300);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        tick();
        stall_exe = 1'b1;
        set_exe(1'b1, 1'b1, 64'h300);
        settle();
        chk("sc_redirect", 64'(redirect), 64'd0);
        tick();
        settle();
        chk("sc_upd_c2",    64'(upd_valid),  64'd1);
        chk("sc_branch_c2", 64'(branch_cnt), 64'd6);
        tick();
        settle();
        chk("sc_upd_c3",    64'(upd_valid),  64'd0);
        chk("sc_branch_c3", 64'(branch_cnt), 64'd6);
        tick();
        settle();
        chk("sc_branch_c4", 64'(branch_cnt), 64'd6);
        stall_exe = 1'b0;
        set_exe(1'b0, 1'b0, '0);
        tick();
        settle();
        chk("sc_upd_after", 64'(upd_valid), 64'd0);

        // Flush with stall_id while a mispredict sits in EXE
        set_if(1'b1, 64'h100, 1'b0, '0);
        tick();
        set_if(1'b1, 64'h104, 1'b1, 64'h200);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        stall_id = 1'b1;
        flush    = 1'b1;
        set_exe(1'b1, 1'b1, 64'h900);
        settle();
        chk("fl_redirect",    64'(redirect), 64'd0);
        chk("fl_redirect_pc", redirect_pc,   64'd0);
        tick();
        stall_id = 1'b0;
        flush    = 1'b0;
        settle();
        chk("fl_idex_cleared", 64'(redirect),   64'd0);
        chk("fl_upd_valid",    64'(upd_valid),  64'd0);
        chk("fl_branch_cnt",   64'(branch_cnt), 64'd6);
        tick();
        settle();
        chk("fl_ifid_cleared", 64'(redirect),   64'd0);
        chk("fl_branch_cnt2",  64'(branch_cnt), 64'd6);
        set_exe(1'b0, 1'b0, '0);

        // Reset in the middle of traffic
        set_if(1'b1, 64'h100, 1'b1, 64'h200);
        tick();
        set_if(1'b1, 64'h40, 1'b1, 64'h80);
        tick();
        set_if(1'b0, '0, 1'b0, '0);
        set_exe(1'b1, 1'b1, 64'h200);
        settle();
        chk("rs_pre_redirect", 64'(redirect), 64'd0);
        tick();
        set_exe(1'b0, 1'b0, '0);
        settle();
        chk("rs_pre_upd",      64'(upd_valid),  64'd1);
        chk("rs_pre_branch",   64'(branch_cnt), 64'd7);
        chk("rs_pre_alias",    64'(redirect),   64'd1);
        rst = 1'b1;
        settle();
        chk_all_zero("rs_mid");
        tick();
        rst = 1'b0;
        tick();
        settle();
        chk("rs_post_redirect", 64'(redirect), 64'd0);
        tick();
        settle();
        chk("rs_post_redirect2", 64'(redirect),   64'd0);
        chk("rs_post_upd",       64'(upd_valid),  64'd0);
        chk("rs_post_branch",    64'(branch_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_resolve_unit
